// File: rtl/nco_channel_sched.sv
// nco_channel_sched: time-shares one pipelined CORDIC between two NCO channels.
// Optional phase dither is enabled by defining NCO_SCHED_DITHER_EN.
module nco_channel_sched #(
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int PW  = 24,
    parameter int LAT = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [7:0]    cfg_wdata,
    output logic          cordic_ce,
    output logic [IW-1:0] cordic_xval,
    output logic [IW-1:0] cordic_yval,
    output logic [PW-1:0] cordic_phase,
    input  logic [OW-1:0] cordic_xo,
    input  logic [OW-1:0] cordic_yo,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_chan,
    output logic [OW-1:0] out_x,
    output logic [OW-1:0] out_y
);

    logic [PW-1:0]  acc_q  [2];
    logic [PW-1:0]  acc_d  [2];
    logic [PW-1:0]  freq_q [2];
    logic [PW-1:0]  freq_d [2];
    logic [7:0]     stLo_q [2];
    logic [7:0]     stLo_d [2];
    logic [7:0]     stHi_q [2];
    logic [7:0]     stHi_d [2];
    logic [7:0]     amp_q  [2];
    logic [7:0]     amp_d  [2];
    logic [1:0]     en_q, en_d;
    logic           ptr_q, ptr_d;
    logic           clr;

    logic           issVld_q, issChan_q;
    logic [PW-1:0]  phase_q;
    logic [IW-1:0]  xval_q;
    logic [LAT-1:0] tagVld_q, tagChan_q;

    logic           outValid_q, outChan_q;
    logic [OW-1:0]  outX_q, outY_q;

    logic           advance, issue, issChan;
    logic [PW-1:0]  issPhase;
    logic           unusedBits;

    assign advance    = !outValid_q || out_ready;
    assign unusedBits = &{1'b0, cfg_wdata[7:3]};

`ifdef NCO_SCHED_DITHER_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'h01;
        end else if (advance && issue) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign issPhase = acc_q[issChan] + {{(PW-8){1'b0}}, lfsr_q};
`else
    assign issPhase = acc_q[issChan];
`endif

    always_comb begin
        issue   = 1'b1;
        issChan = 1'b0;
        case (en_q)
            2'b11:   issChan = ptr_q;
            2'b10:   issChan = 1'b1;
            2'b01:   issChan = 1'b0;
            default: issue   = 1'b0;
        endcase
        ptr_d = (advance && en_q == 2'b11) ? ~ptr_q : ptr_q;

        en_d = en_q;
        clr  = 1'b0;
        if (cfg_we && cfg_addr == 4'd8) begin
            en_d = cfg_wdata[1:0];
            clr  = cfg_wdata[2];
        end

        // Address bit 2 selects the channel, bits 1:0 the byte within it.
        for (int c = 0; c < 2; c++) begin
            acc_d[c]  = acc_q[c];
            freq_d[c] = freq_q[c];
            stLo_d[c] = stLo_q[c];
            stHi_d[c] = stHi_q[c];
            amp_d[c]  = amp_q[c];
            if (advance && issue && issChan == 1'(c)) begin
                acc_d[c] = acc_q[c] + freq_q[c];
            end
            if (cfg_we && !cfg_addr[3] && cfg_addr[2] == 1'(c)) begin
                case (cfg_addr[1:0])
                    2'd0:    stLo_d[c] = cfg_wdata;
                    2'd1:    stHi_d[c] = cfg_wdata;
                    2'd2:    freq_d[c] = PW'({cfg_wdata, stHi_q[c], stLo_q[c]});
                    default: amp_d[c]  = cfg_wdata;
                endcase
            end
            if (clr) begin
                acc_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                acc_q[c]  <= '0;
                freq_q[c] <= '0;
                stLo_q[c] <= '0;
                stHi_q[c] <= '0;
                amp_q[c]  <= '0;
            end
            en_q  <= '0;
            ptr_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                acc_q[c]  <= acc_d[c];
                freq_q[c] <= freq_d[c];
                stLo_q[c] <= stLo_d[c];
                stHi_q[c] <= stHi_d[c];
                amp_q[c]  <= amp_d[c];
            end
            en_q  <= en_d;
            ptr_q <= ptr_d;
        end
    end

    // The issue tag sits beside the registered CORDIC inputs and enters the
    // tag pipe on the same edge the CORDIC captures those inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issVld_q  <= 1'b0;
            issChan_q <= 1'b0;
            phase_q   <= '0;
            xval_q    <= '0;
            tagVld_q  <= '0;
            tagChan_q <= '0;
        end else if (advance) begin
            issVld_q  <= issue;
            issChan_q <= issChan;
            phase_q   <= issue ? issPhase : '0;
            xval_q    <= issue ? {amp_q[issChan], {(IW-8){1'b0}}} : '0;
            tagVld_q  <= {tagVld_q[LAT-2:0], issVld_q};
            tagChan_q <= {tagChan_q[LAT-2:0], issChan_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outChan_q  <= 1'b0;
            outX_q     <= '0;
            outY_q     <= '0;
        end else if (advance && tagVld_q[LAT-1]) begin
            outValid_q <= 1'b1;
            outChan_q  <= tagChan_q[LAT-1];
            outX_q     <= cordic_xo;
            outY_q     <= cordic_yo;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign cordic_ce    = advance;
    assign cordic_phase = phase_q;
    assign cordic_xval  = xval_q;
    assign cordic_yval  = '0;
    assign out_valid    = outValid_q;
    assign out_chan     = outChan_q;
    assign out_x        = outX_q;
    assign out_y        = outY_q;

endmodule

// File: tb/tb_nco_channel_sched.sv
// Scoreboard bench for nco_channel_sched with a delay-line stand-in for the CORDIC.
module tb_nco_channel_sched;

    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int PW  = 24;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [7:0]    cfg_wdata = '0;
    logic          out_ready = 1'b0;
    logic          cordic_ce;
    logic [IW-1:0] cordic_xval, cordic_yval;
    logic [PW-1:0] cordic_phase;
    logic [OW-1:0] cordic_xo, cordic_yo;
    logic          out_valid, out_chan;
    logic [OW-1:0] out_x, out_y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int firstIssueCyc = -1;
    logic chkEn = 1'b0;

    nco_channel_sched #(.IW(IW), .OW(OW), .PW(PW), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cordic_ce(cordic_ce), .cordic_xval(cordic_xval), .cordic_yval(cordic_yval),
        .cordic_phase(cordic_phase), .cordic_xo(cordic_xo), .cordic_yo(cordic_yo),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_x(out_x), .out_y(out_y)
    );

    always #5 clk = ~clk;

    // Stand-in CORDIC: LAT clock-enabled stages whose result encodes phase and amplitude.
    logic [31:0] cordicPipe [LAT];
    always @(posedge clk) begin
        if (cordic_ce) begin
            for (int i = LAT - 1; i > 0; i--) cordicPipe[i] <= cordicPipe[i-1];
            cordicPipe[0] <= {cordic_phase, cordic_xval[IW-1:8]};
        end
    end
    assign cordic_xo = cordicPipe[LAT-1][31:16];
    assign cordic_yo = cordicPipe[LAT-1][15:0];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Snapshot the DUT mid-cycle; the model consumes these at the next rising edge.
    logic          sOv = 0, sRdy = 0, sChan = 0, sCe = 0, sWe = 0;
    logic [OW-1:0] sX = 0, sY = 0;
    logic [PW-1:0] sPhase = 0;
    logic [IW-1:0] sXval = 0, sYval = 0;
    logic [3:0]    sAddr = 0;
    logic [7:0]    sWdata = 0;
    always @(negedge clk) begin
        sOv <= out_valid;  sRdy <= out_ready; sChan <= out_chan; sCe <= cordic_ce;
        sX <= out_x;       sY <= out_y;       sPhase <= cordic_phase;
        sXval <= cordic_xval; sYval <= cordic_yval;
        sWe <= cfg_we;     sAddr <= cfg_addr; sWdata <= cfg_wdata;
    end

    // Reference scheduler: expected results are pushed when a sample is issued.
    logic [32:0]   sbQ [$];
    logic [PW-1:0] mAcc [2];
    logic [PW-1:0] mFreq [2];
    logic [7:0]    mLo [2];
    logic [7:0]    mHi [2];
    logic [7:0]    mAmp [2];
    logic [1:0]    mEn;
    logic          mPtr;
    logic [PW-1:0] mPhase;
    logic [IW-1:0] mXval;
    logic [7:0]    mLfsr;

    initial begin
        logic [32:0] want;
        logic        c, doIssue;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    mAcc[i] = '0; mFreq[i] = '0; mLo[i] = '0; mHi[i] = '0; mAmp[i] = '0;
                end
                mEn = '0; mPtr = 1'b0; mPhase = '0; mXval = '0; mLfsr = 8'h01;
                sbQ.delete();
            end else begin
                cyc++;
                if (chkEn) begin
                    checkOutput("ce", sCe, !sOv || sRdy);
                    checkOutput("phase", sPhase, mPhase);
                    checkOutput("xval", sXval, mXval);
                    checkOutput("yval", sYval, 0);
                    if (sOv && sRdy) begin
                        if (sbQ.size() == 0) begin
                            checkOutput("unexpectedOut", 1, 0);
                        end else begin
                            want = sbQ.pop_front();
                            checkOutput("outChan", sChan, want[32]);
                            checkOutput("outX", sX, want[31:16]);
                            checkOutput("outY", sY, want[15:0]);
                        end
                    end
                end
                if (!sOv || sRdy) begin
                    doIssue = (mEn != 2'b00);
                    c = (mEn == 2'b11) ? mPtr : mEn[1] && !mEn[0];
                    if (doIssue) begin
`ifdef NCO_SCHED_DITHER_EN
                        mPhase = mAcc[c] + {{(PW-8){1'b0}}, mLfsr};
                        mLfsr  = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
`else
                        mPhase = mAcc[c];
`endif
                        mXval = {mAmp[c], 8'h00};
                        sbQ.push_back({c, mPhase, mAmp[c]});
                        if (firstIssueCyc < 0) firstIssueCyc = cyc;
                        mAcc[c] = mAcc[c] + mFreq[c];
                        if (mEn == 2'b11) mPtr = !mPtr;
                    end else begin
                        mPhase = '0;
                        mXval  = '0;
                    end
                end
                if (sWe && sAddr == 4'd8) begin
                    mEn = sWdata[1:0];
                    if (sWdata[2]) begin
                        mAcc[0] = '0;
                        mAcc[1] = '0;
                    end
                end else if (sWe && !sAddr[3]) begin
                    c = sAddr[2];
                    case (sAddr[1:0])
                        2'd0:    mLo[c] = sWdata;
                        2'd1:    mHi[c] = sWdata;
                        2'd2:    mFreq[c] = {sWdata, mHi[c], mLo[c]};
                        default: mAmp[c] = sWdata;
                    endcase
                end
            end
        end
    end

    // Drives one config write; called and returns 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [OW-1:0] holdX, holdY;
        int k;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstCe", cordic_ce, 1);
        checkOutput("rstPhase", cordic_phase, 0);
        checkOutput("rstX", out_x, 0);
        rst_n = 1'b1;
        chkEn = 1'b1;
        out_ready = 1'b1;
        runCycles(2);

        // Channel 0 alone, freq 0x000100; the enable edge is followed by the first issue.
        applyStimulus(4'd0, 8'h00);
        applyStimulus(4'd1, 8'h01);
        applyStimulus(4'd2, 8'h00);
        applyStimulus(4'd3, 8'hA5);
        applyStimulus(4'd8, 8'h01);
        k = 0;
        while (k < 100 && !out_valid) begin
            runCycles(1);
            k++;
        end
        checkOutput("firstValid", out_valid, 1);
        checkOutput("latency", cyc - firstIssueCyc, LAT + 1);
        checkOutput("firstChan", out_chan, 0);
        runCycles(10);

        // Both channels alternate.
        applyStimulus(4'd4, 8'h10);
        applyStimulus(4'd5, 8'h00);
        applyStimulus(4'd6, 8'h00);
        applyStimulus(4'd7, 8'h3C);
        applyStimulus(4'd8, 8'h03);
        runCycles(LAT + 10);

        // Five-cycle stall with a result held.
        k = 0;
        while (k < 100 && !out_valid) begin
            runCycles(1);
            k++;
        end
        checkOutput("stallValid", out_valid, 1);
        out_ready = 1'b0;
        holdX = out_x;
        holdY = out_y;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stallCe", cordic_ce, 0);
            checkOutput("stallHoldX", out_x, holdX);
            checkOutput("stallHoldY", out_y, holdY);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        runCycles(10);

        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            runCycles(1);
        end
        out_ready = 1'b1;

        // Wrap with freq 0xFFFFFF; partial byte writes must not change the frequency.
        applyStimulus(4'd8, 8'h04);
        applyStimulus(4'd0, 8'hFF);
        applyStimulus(4'd1, 8'hFF);
        applyStimulus(4'd2, 8'hFF);
        applyStimulus(4'd8, 8'h01);
        runCycles(10);
        applyStimulus(4'd0, 8'h55);
        applyStimulus(4'd1, 8'h66);
        runCycles(10);
        applyStimulus(4'd2, 8'h00);
        runCycles(10);

        // Clear while channel 0 issues every cycle.
        applyStimulus(4'd8, 8'h05);
        runCycles(1);
`ifndef NCO_SCHED_DITHER_EN
        checkOutput("clrPhase", cordic_phase, 0);
`endif
        runCycles(LAT + 5);

        // Disable channel 1 mid-run, then everything, and drain.
        applyStimulus(4'd8, 8'h03);
        runCycles(15);
        applyStimulus(4'd8, 8'h01);
        runCycles(15);
        applyStimulus(4'd8, 8'h00);
        runCycles(LAT + 5);
        checkOutput("drainQueue", sbQ.size(), 0);
        checkOutput("drainValid", out_valid, 0);

        // Asynchronous reset in the middle of traffic.
        applyStimulus(4'd8, 8'h03);
        runCycles(LAT + 5);
        #2;
        chkEn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstX", out_x, 0);
        checkOutput("midRstY", out_y, 0);
        checkOutput("midRstPhase", cordic_phase, 0);
        checkOutput("midRstXval", cordic_xval, 0);
        checkOutput("midRstCe", cordic_ce, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chkEn = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            runCycles(1);
            checkOutput("noStale", out_valid, 0);
        end
        applyStimulus(4'd0, 8'h20);
        applyStimulus(4'd2, 8'h00);
        applyStimulus(4'd3, 8'h77);
        applyStimulus(4'd8, 8'h01);
        runCycles(LAT + 10);
        applyStimulus(4'd8, 8'h00);
        runCycles(LAT + 5);
        checkOutput("finalQueue", sbQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_channel_sched.md
Name: nco_channel_sched

Overview:
- Time-shares one pipelined cordic_nco instance between two NCO channels.
- Each channel has its own phase accumulator, frequency word and amplitude.
- Block issues one rotation per advance cycle, tracks the channel tag of every in-flight sample through the CORDIC latency, and presents results on a valid/ready output port.
- Configured over a byte-wide write bus so it maps directly onto the 8-bit user IO.

Parameters:
- IW, 16, CORDIC input width (x/y)
- OW, 16, CORDIC output width
- PW, 24, phase/accumulator width
- LAT, 20, CORDIC latency in i_ce-enabled cycles (equals NSTAGES of the instance)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_addr  in  4  config register address
- cfg_wdata  in  8  config write data
- cordic_ce  out  1  clock enable to CORDIC; also advances the tag pipe
- cordic_xval  out  IW  CORDIC x input
- cordic_yval  out  IW  CORDIC y input
- cordic_phase  out  PW  CORDIC phase input
- cordic_xo  in  OW  CORDIC x result
- cordic_yo  in  OW  CORDIC y result
- out_valid  out  1  result holding register full
- out_ready  in  1  consumer accepts result
- out_chan  out  1  channel of held result
- out_x  out  OW  held x result
- out_y  out  OW  held y result

Behaviour:
- Reset (async on rst_n low), all to 0:
  - accumulators, frequency words, staging bytes, amplitudes, enables
  - round-robin pointer, tag pipe, out_valid/out_chan/out_x/out_y
  - cordic_ce is 1 in reset.
- Register map (writes only, other addresses ignored):
  - 0,1,2: ch0 freq bytes LSB..MSB
  - 3: ch0 amp
  - 4,5,6: ch1 freq bytes LSB..MSB
  - 7: ch1 amp
  - 8: control. bit0 en0, bit1 en1, bit2 clr (self-clearing, not stored).
- Freq update is atomic:
  - Bytes 0/1 (4/5) go to staging.
  - Writing byte 2 (6) commits {wdata, stage1, stage0} into the active freq word on the next edge.
- advance = !out_valid || out_ready; cordic_ce = advance (combinational).
- Issue decision on each advance cycle:
  - Both enabled: alternate; pointer toggles after each issue, ch0 first after reset.
  - One enabled: issue it every advance cycle.
  - None enabled: issue bubble (tag valid=0).
- Issue of channel c:
  - cordic_phase = acc_c
  - cordic_xval = {amp_c, 8'h00}
  - cordic_yval = 0
  - acc_c <= acc_c + freq_c, mod 2^PW, wraps silently.
  - Inputs are driven registered, aligned with cordic_ce high.
- Tag pipe:
  - LAT-deep shift of {valid, chan}; shifts only when advance = 1.
  - The tag leaving the pipe in the same cycle cordic_xo/yo present that sample's result loads the holding register when valid.
- Holding register:
  - Loaded when advance and tag-out valid.
  - out_valid cleared on out_ready with no new load.
  - Load and drain in the same cycle: new data replaces old, out_valid stays 1.
- Stall: out_valid=1 and out_ready=0 → cordic_ce=0, pipe frozen, accumulators frozen, no issue, no data loss.
- Latency: an issue at advance cycle n appears as out_valid after exactly LAT+1 advance cycles.
- clr:
  - Zeroes both accumulators next edge; clr wins over a same-cycle accumulate.
  - In-flight samples are not flushed.
- Disable mid-run: no new issues for that channel; its in-flight samples still delivered.
- cfg writes are accepted during stall.

Optional Feature:
- Macro NCO_SCHED_DITHER_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01 at reset) advances on each issue.
  - cordic_phase = acc_c + {PW-8 zeros, lfsr}; the accumulator itself is undithered.
- Undefined: cordic_phase = acc_c exactly; no LFSR logic.

Test Plan:
- Reset then write freq0=24'h000100 via addr 0,1,2, en0=1, out_ready=1 → issued phases 0, 0x100, 0x200, …; first out_valid with out_chan=0 at LAT+1 cycles after first issue.
- en0=en1=1, freq1=24'h000010 → out_chan alternates 0,1,0,1; ch0 phases step 0x100 and ch1 phases step 0x10, each per own issue.
- Hold out_ready=0 for 5 cycles with valid output → cordic_ce=0 for those cycles, out_x/out_y stable; no sample lost or duplicated after release (sequence continuity checked).
- freq0=24'hFFFFFF, ch0 only → accumulator wraps to 0xFFFFFF, 0xFFFFFE, …; write byte0/1 only → freq unchanged until byte2 write.
- Write clr in the same cycle as a ch0 issue → acc0=0 next cycle; in-flight results still emerge with correct tags.
- Assert rst_n low mid-stream (async, between edges) → all outputs 0 immediately; after release no stale out_valid.
